// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile -- 31 x WIDTH general-purpose register file with a hard-wired zero
// register, two combinational read ports and one synchronous write port.
//
// Ports
//   clk            in   1      rising-edge clock for all state
//   reset          in   1      synchronous active-high clear of X0..X30
//   RegWrite       in   1      write enable
//   WriteRegister  in   5      write address (31 = XZR, writes discarded)
//   WriteData      in   WIDTH  write data
//   ReadRegister1  in   5      read port 1 address
//   ReadRegister2  in   5      read port 2 address
//   ReadData1      out  WIDTH  read port 1 data (combinational)
//   ReadData2      out  WIDTH  read port 2 data (combinational)
//
// Address 31 (XZR) has no storage and always reads zero. A write to the
// same address a port is reading is forwarded combinationally so a value
// written back in a cycle is visible to a decode in that same cycle.
// ---------------------------------------------------------------------------
module regfile #(
    parameter int WIDTH = 64,
    parameter int NREG  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWrite,
    input  logic [4:0]       WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  logic [4:0]       ReadRegister1,
    input  logic [4:0]       ReadRegister2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2
);

    // Highest address is the zero register and gets no flops.
    localparam int NSTORE = NREG - 1;
    localparam logic [4:0] ZR_ADDR = 5'd31;

    logic [WIDTH-1:0] regs [NSTORE];

    // ------------------------------------------------------------------
    // Write decode: one-hot 5:32 decoder gated by RegWrite. The XZR
    // enable is forced low so a write to 31 simply vanishes.
    // ------------------------------------------------------------------
    logic [NREG-1:0] wr_en;

    always_comb begin
        wr_en = '0;
        if (RegWrite) begin
            wr_en[WriteRegister] = 1'b1;
        end
        wr_en[ZR_ADDR] = 1'b0;
    end

    // ------------------------------------------------------------------
    // Storage: reset wins over any write on the same edge.
    // ------------------------------------------------------------------
    for (genvar r = 0; r < NSTORE; r++) begin : g_reg
        always_ff @(posedge clk) begin
            if (reset) begin
                regs[r] <= '0;
            end else if (wr_en[r]) begin
                regs[r] <= WriteData;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path: transpose storage into per-bit columns so each output
    // bit is a 32:1 mux selected by the read address. Column entry 31
    // is a constant zero.
    // ------------------------------------------------------------------
    logic [NREG-1:0]  bit_col [WIDTH];
    logic [WIDTH-1:0] stored1;
    logic [WIDTH-1:0] stored2;

    always_comb begin
        for (int b = 0; b < WIDTH; b++) begin
            bit_col[b] = '0;
            for (int r = 0; r < NSTORE; r++) begin
                bit_col[b][r] = regs[r][b];
            end
        end
    end

    always_comb begin
        stored1 = '0;
        stored2 = '0;
        for (int b = 0; b < WIDTH; b++) begin
            stored1[b] = bit_col[b][ReadRegister1];
            stored2[b] = bit_col[b][ReadRegister2];
        end
    end

    // ------------------------------------------------------------------
    // Write-to-read bypass. Never for XZR, and suppressed during reset
    // so the outputs then show what is actually stored.
    // ------------------------------------------------------------------
    logic wr_live;
    logic bypass1;
    logic bypass2;

    assign wr_live = RegWrite && !reset && (WriteRegister != ZR_ADDR);
    assign bypass1 = wr_live && (WriteRegister == ReadRegister1);
    assign bypass2 = wr_live && (WriteRegister == ReadRegister2);

    assign ReadData1 = bypass1 ? WriteData : stored1;
    assign ReadData2 = bypass2 ? WriteData : stored2;

endmodule

// File: tb/tb_regfile.sv
// ---------------------------------------------------------------------------
// tb_regfile -- self-checking bench for regfile (WIDTH=64).
// Directed vector table, hand sequences for reset / cold read, then a
// randomized run against an array model of the architectural registers.
// ---------------------------------------------------------------------------
module tb_regfile;

    localparam int W = 64;

    logic         clk;
    logic         reset;
    logic         RegWrite;
    logic [4:0]   WriteRegister;
    logic [W-1:0] WriteData;
    logic [4:0]   ReadRegister1;
    logic [4:0]   ReadRegister2;
    logic [W-1:0] ReadData1;
    logic [W-1:0] ReadData2;

    int tests_run = 0;
    int tests_failed = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] model_mem [32];

    regfile #(.WIDTH(W), .NREG(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [W-1:0] act);
        logic [W-1:0] exp;
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL %s: no expected value queued (actual %h)", name, act);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                tests_failed++;
                $display("FAIL %s: actual %h required %h", name, act, exp);
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                         input logic [W-1:0] wd, input logic [4:0] ra1,
                         input logic [4:0] ra2);
        reset         = rst;
        RegWrite      = we;
        WriteRegister = wa;
        WriteData     = wd;
        ReadRegister1 = ra1;
        ReadRegister2 = ra2;
    endtask

    // Reference read: architectural register value, zero register, bypass.
    function automatic logic [W-1:0] model_read(input logic rst, input logic we,
                                                input logic [4:0] wa,
                                                input logic [W-1:0] wd,
                                                input logic [4:0] ra);
        if (ra == 5'd31) return '0;
        if (!rst && we && wa == ra) return wd;
        return model_mem[ra];
    endfunction

    task automatic model_edge(input logic rst, input logic we,
                              input logic [4:0] wa, input logic [W-1:0] wd);
        if (rst) begin
            for (int i = 0; i < 32; i++) model_mem[i] = '0;
        end else if (we && wa != 5'd31) begin
            model_mem[wa] = wd;
        end
    endtask

    // Sweep every address on both ports with writes disabled; expect model.
    task automatic sweep(input string name);
        for (int a = 0; a < 32; a++) begin
            drive(1'b0, 1'b0, 5'd0, '0, 5'(a), 5'(31 - a));
            #1;
            exp_q.push_back(model_read(1'b0, 1'b0, 5'd0, '0, 5'(a)));
            check(name, ReadData1);
            exp_q.push_back(model_read(1'b0, 1'b0, 5'd0, '0, 5'(31 - a)));
            check(name, ReadData2);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic         rst;
        logic         we;
        logic [4:0]   wa;
        logic [W-1:0] wd;
        logic [4:0]   ra1;
        logic [4:0]   ra2;
        logic [W-1:0] exp1;
        logic [W-1:0] exp2;
    } vec_t;

    vec_t vecs [15];

    localparam logic [W-1:0] DB   = 64'hDEADBEEF_CAFEF00D;
    localparam logic [W-1:0] ONES = '1;

    initial begin
        logic         r_rst;
        logic         r_we;
        logic [4:0]   r_wa;
        logic [W-1:0] r_wd;
        logic [4:0]   r_ra1;
        logic [4:0]   r_ra2;

        // Expected values are the outputs just before each vector's edge.
        vecs[0]  = '{0, 1, 5,  DB,       5,  0,  DB,       0};
        vecs[1]  = '{0, 1, 30, 64'h1,    5,  30, DB,       64'h1};
        vecs[2]  = '{0, 0, 30, 64'hFFFF, 5,  30, DB,       64'h1};
        vecs[3]  = '{0, 0, 0,  0,        31, 4,  0,        0};
        vecs[4]  = '{0, 1, 31, ONES,     31, 31, 0,        0};
        vecs[5]  = '{0, 0, 0,  0,        31, 5,  0,        DB};
        vecs[6]  = '{0, 1, 7,  64'hA,    7,  7,  64'hA,    64'hA};
        vecs[7]  = '{0, 1, 7,  64'hB,    7,  7,  64'hB,    64'hB};
        vecs[8]  = '{0, 0, 7,  64'hC,    7,  7,  64'hB,    64'hB};
        vecs[9]  = '{0, 1, 3,  64'h55,   3,  3,  64'h55,   64'h55};
        vecs[10] = '{1, 1, 3,  64'h77,   3,  5,  64'h55,   DB};
        vecs[11] = '{1, 0, 0,  0,        3,  5,  0,        0};
        vecs[12] = '{0, 0, 0,  0,        3,  30, 0,        0};
        vecs[13] = '{0, 1, 0,  64'h123,  0,  1,  64'h123,  0};
        vecs[14] = '{0, 0, 0,  0,        0,  0,  64'h123,  64'h123};

        drive(1'b1, 1'b0, 5'd0, '0, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) model_mem[i] = '0;

        // Reset for one edge then cold-read every address.
        @(negedge clk);
        sweep("cold_read");

        for (int v = 0; v < 15; v++) begin
            @(negedge clk);
            drive(vecs[v].rst, vecs[v].we, vecs[v].wa, vecs[v].wd,
                  vecs[v].ra1, vecs[v].ra2);
            #2;
            exp_q.push_back(vecs[v].exp1);
            check($sformatf("vec%0d_rd1", v), ReadData1);
            exp_q.push_back(vecs[v].exp2);
            check($sformatf("vec%0d_rd2", v), ReadData2);
            model_edge(vecs[v].rst, vecs[v].we, vecs[v].wa, vecs[v].wd);
        end

        // Full sweep after the table: only X0 should hold data.
        @(negedge clk);
        sweep("post_table_sweep");

        // ---------------- randomized run ----------------
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            r_rst = ($urandom_range(0, 99) < 2);
            r_we  = ($urandom_range(0, 3) != 0);
            r_wa  = 5'($urandom_range(0, 31));
            r_wd  = {$urandom, $urandom};
            r_ra1 = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom_range(0, 31));
            r_ra2 = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom_range(0, 31));
            drive(r_rst, r_we, r_wa, r_wd, r_ra1, r_ra2);
            #2;
            exp_q.push_back(model_read(r_rst, r_we, r_wa, r_wd, r_ra1));
            check("rand_rd1", ReadData1);
            exp_q.push_back(model_read(r_rst, r_we, r_wa, r_wd, r_ra2));
            check("rand_rd2", ReadData2);
            model_edge(r_rst, r_we, r_wa, r_wd);
        end

        // Populate every register, confirm, then a mid-sequence reset must
        // wipe them all.
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            r_wd = {$urandom, $urandom} | 64'h1;
            drive(1'b0, 1'b1, 5'(a), r_wd, 5'd31, 5'd31);
            model_edge(1'b0, 1'b1, 5'(a), r_wd);
        end
        @(negedge clk);
        sweep("populated_sweep");
        drive(1'b1, 1'b1, 5'd9, ONES, 5'd9, 5'd9);
        model_edge(1'b1, 1'b1, 5'd9, ONES);
        @(negedge clk);
        sweep("mid_reset_sweep");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
